hazard_unit: RTL

Pipeline hazard controller and destination-register tracker for the five-stage RV32I core. It records the destination register, write enable and load flag of every instruction in flight in EX, MEM and WB, and drives those fields to the forwarding logic as `rd_*` / `we_rf_*`. It detects load-use hazards and stalls PC and IF/ID for one cycle while inserting a bubble into ID/EX. It also flushes IF/ID and ID/EX when EX resolves a taken branch or jump, and keeps stall/flush event counters for debug.

---
 rtl/hazard_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Hazard controller and destination-register tracker for the five-stage RV32I
// pipeline.
//
// Tracker: three registered entries {valid, rd, we, is_load} follow the
// instructions sitting in EX, MEM and WB. The forwarding logic reads them as
// rd_* / we_rf_*.
//
// Hazards:
//   - Load-use: a valid load in EX whose rd is read by the ID instruction.
//     PC and IF/ID are held for one cycle, and a bubble enters ID/EX.
//   - Control: a taken branch or a jump resolved in EX. IF/ID and ID/EX are
//     flushed. This takes priority over a simultaneous load-use.
//
// Debug: stall/flush event counters plus a small mode FSM (RUN/STALL/FLUSH).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   rs1_id, rs2_id             ID source registers
//   use_rs1_id, use_rs2_id     ID instruction actually reads rs1 / rs2
//   rd_id, we_rf_id            ID destination and register-file write enable
//   is_load_id                 ID instruction is a load
//   branch_taken_ex, jump_ex   control transfer resolved in EX
//   rd_ex/mem/wb               tracked destinations (0 for bubbles)
//   we_rf_ex/mem/wb            tracked write enables (valid & we)
//   load_ex                    EX entry is a valid load
//   stall_pc, stall_if_id      hold PC and IF/ID
//   flush_if_id, flush_id_ex   squash IF/ID; bubble into ID/EX
//   stall_cnt, flush_cnt       wrapping event counters
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [4:0]       rd_id,
    input  logic             we_rf_id,
    input  logic             is_load_id,
    input  logic             branch_taken_ex,
    input  logic             jump_ex,
    output logic [4:0]       rd_ex,
    output logic [4:0]       rd_mem,
    output logic [4:0]       rd_wb,
    output logic             we_rf_ex,
    output logic             we_rf_mem,
    output logic             we_rf_wb,
    output logic             load_ex,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } entry_t;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_STALL = 2'd1,
        MODE_FLUSH = 2'd2
    } mode_e;

    localparam entry_t BUBBLE = '{valid: 1'b0, rd: 5'd0, we: 1'b0, is_load: 1'b0};

    entry_t           ex_q, mem_q, wb_q, ex_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;          // load-use hazard against the EX entry
    logic ctl;         // control transfer resolved in EX
    logic do_stall;    // stall that actually takes effect (flush wins)
    logic do_bubble;   // ID/EX receives a bubble this cycle

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in an always_comb gets a value on every
        // path (defaults first); otherwise synthesis infers a latch.
        lu        = 1'b0;
        ctl       = branch_taken_ex | jump_ex;
        if (id_valid && ex_q.valid && ex_q.is_load && ex_q.we && (ex_q.rd != 5'd0)) begin
            lu = (use_rs1_id && (rs1_id == ex_q.rd)) ||
                 (use_rs2_id && (rs2_id == ex_q.rd));
        end
        do_stall  = lu & ~ctl;
        do_bubble = lu | ctl;
    end

    // Hazard controls are forced low while reset is asserted so a core held in
    // reset never sees a spurious hold or squash.
    assign stall_pc    = rst_n & do_stall;
    assign stall_if_id = rst_n & do_stall;
    assign flush_if_id = rst_n & ctl;
    assign flush_id_ex = rst_n & do_bubble;

    // -----------------------------------------------------------------------
    // Tracker next state: only EX can take a bubble; MEM and WB always shift.
    // The branch/jump itself is in EX and moves on to MEM untouched.
    // -----------------------------------------------------------------------
    always_comb begin
        ex_d = BUBBLE;
        if (!do_bubble) begin
            ex_d = '{valid: id_valid, rd: rd_id, we: we_rf_id, is_load: is_load_id};
        end
    end

    // -----------------------------------------------------------------------
    // Counters and debug mode FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (do_stall) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ctl)      flush_cnt_d = flush_cnt_q + CNT_W'(1);

        mode_d = mode_q;
        case (mode_q)
            MODE_RUN: begin
                if (ctl)           mode_d = MODE_FLUSH;
                else if (do_stall) mode_d = MODE_STALL;
            end
            MODE_STALL: begin
                mode_d = ctl ? MODE_FLUSH : MODE_RUN;
            end
            MODE_FLUSH: begin
                mode_d = do_stall ? MODE_STALL : MODE_RUN;
            end
            default: mode_d = MODE_RUN;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            mode_q      <= MODE_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make the EX->MEM->WB shift read
            // the old values of every stage, so the order here is irrelevant.
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            mode_q      <= mode_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Registered tracker outputs, masked by valid
    // -----------------------------------------------------------------------
    assign rd_ex     = ex_q.valid  ? ex_q.rd  : 5'd0;
    assign rd_mem    = mem_q.valid ? mem_q.rd : 5'd0;
    assign rd_wb     = wb_q.valid  ? wb_q.rd  : 5'd0;
    assign we_rf_ex  = ex_q.valid  & ex_q.we;
    assign we_rf_mem = mem_q.valid & mem_q.we;
    assign we_rf_wb  = wb_q.valid  & wb_q.we;
    assign load_ex   = ex_q.valid  & ex_q.is_load;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
